// File: rtl/icache_line_reader.sv
// Instruction-fetch line reader: serves prefetch requests from a single 16-byte line
// buffer (refilled over the code-read port) and streams 1-4 byte fragments to the prefetch FIFO.
module icache_line_reader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pr_reset,
    input  logic        invalidate_do,
    input  logic        icacheread_do,
    input  logic [31:0] icacheread_address,
    input  logic [4:0]  icacheread_length,
    input  logic        icacheread_cache_disable,
    output logic        readcode_do,
    output logic [31:0] readcode_address,
    output logic        readcode_single,
    input  logic        readcode_partial_done,
    input  logic [31:0] readcode_partial,
    input  logic        readcode_done,
    output logic        prefetchfifo_write_do,
    output logic [35:0] prefetchfifo_write_data,
    output logic        prefetched_do,
    output logic [4:0]  prefetched_length
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        DELIVER = 2'd2,
        ABORT   = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic         line_valid;
    logic [27:0]  line_tag;
    logic [127:0] line_data;
    logic [31:0]  req_addr;
    logic [4:0]   remain;
    logic         req_cd;
    logic [1:0]   dw_idx;

    logic         accept;
    logic         req_hit;
    logic [3:0]   off;
    logic [4:0]   dw_room;
    logic [4:0]   line_room;
    logic [4:0]   limit;
    logic [4:0]   cnt;
    logic [31:0]  dword;
    logic [31:0]  shifted;
    logic [31:0]  mask;
    logic [31:0]  frag;
    logic         last_write;
    logic         write_en;

    // Fragment sizing: a write never crosses a dword, the request length, or the
    // region the request may use (rest of the line, or rest of the dword if uncached).
    always_comb begin : datapath
        off       = req_addr[3:0];
        dw_room   = 5'd4 - {3'b000, off[1:0]};
        line_room = 5'd16 - {1'b0, off};
        limit     = req_cd ? dw_room : line_room;
        cnt       = dw_room;
        if (remain < cnt) begin
            cnt = remain;
        end
        if (limit < cnt) begin
            cnt = limit;
        end
        dword   = line_data[{off[3:2], 5'b00000} +: 32];
        shifted = dword >> {off[1:0], 3'b000};
        case (cnt[2:0])
            3'd1:    mask = 32'h0000_00ff;
            3'd2:    mask = 32'h0000_ffff;
            3'd3:    mask = 32'h00ff_ffff;
            default: mask = 32'hffff_ffff;
        endcase
        frag       = shifted & mask;
        last_write = (remain == cnt) || (cnt == limit);
        accept     = icacheread_do && (icacheread_length != 5'd0) && !pr_reset;
        req_hit    = !icacheread_cache_disable && line_valid &&
                     (line_tag == icacheread_address[31:4]);
    end

    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin : fsm_next
        state_nx         = state;
        write_en         = 1'b0;
        readcode_do      = 1'b0;
        readcode_single  = 1'b0;
        readcode_address = 32'h0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = req_hit ? DELIVER : FILL;
                end
            end
            FILL: begin
                readcode_do = 1'b1;
                if (pr_reset) begin
                    state_nx = readcode_done ? IDLE : ABORT;
                end else if (readcode_done) begin
                    state_nx = DELIVER;
                end
            end
            DELIVER: begin
                if (pr_reset) begin
                    state_nx = IDLE;
                end else begin
                    write_en = 1'b1;
                    if (last_write) begin
                        state_nx = IDLE;
                    end
                end
            end
            ABORT: begin
                // The burst already issued must run to completion on the memory port.
                readcode_do = 1'b1;
                if (readcode_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (readcode_do) begin
            readcode_single  = req_cd;
            readcode_address = req_cd ? {req_addr[31:2], 2'b00} : {req_addr[31:4], 4'h0};
        end
        prefetchfifo_write_do   = write_en;
        prefetchfifo_write_data = write_en ? {cnt[3:0], frag} : 36'h0;
        prefetched_do           = write_en;
        prefetched_length       = write_en ? cnt : 5'd0;
    end

    always_ff @(posedge clk) begin : line_regs
        if (!rst_n) begin
            line_valid <= 1'b0;
            line_tag   <= 28'h0;
            line_data  <= 128'h0;
            req_addr   <= 32'h0;
            remain     <= 5'd0;
            req_cd     <= 1'b0;
            dw_idx     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_addr <= icacheread_address;
                        remain   <= icacheread_length;
                        req_cd   <= icacheread_cache_disable;
                        dw_idx   <= icacheread_cache_disable ? icacheread_address[3:2] : 2'd0;
                    end
                end
                FILL: begin
                    if (readcode_partial_done) begin
                        line_data[{dw_idx, 5'b00000} +: 32] <= readcode_partial;
                        dw_idx <= dw_idx + 2'd1;
                    end
                    if (pr_reset) begin
                        line_valid <= 1'b0;
                    end else if (readcode_done) begin
                        line_valid <= !req_cd;
                        if (!req_cd) begin
                            line_tag <= req_addr[31:4];
                        end
                    end
                end
                DELIVER: begin
                    if (write_en) begin
                        req_addr <= req_addr + {27'h0, cnt};
                        remain   <= remain - cnt;
                    end
                end
                default: ;
            endcase
            // Invalidation wins over a same-cycle refill completion.
            if (invalidate_do) begin
                line_valid <= 1'b0;
            end
        end
    end

endmodule
